// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first,
// with ten's-complement subtract, carry/borrow chaining and an invalid-digit flag.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic            carry;
  logic            invalid_r;
  logic            any_bad;
  logic [3:0]      a_d;
  logic [3:0]      b_d;
  logic [3:0]      bd;
  logic [4:0]      t;
  logic [3:0]      digit;
  logic            carry_nxt;
  logic [W-1:0]    sum_nxt;
  logic            busy_nxt;
  logic            done_nxt;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(DIGITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is ignored while digits are in flight
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE_S;
      DONE_S:  state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so busy/done can be registered
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      RUN:     busy_nxt = 1'b1;
      DONE_S:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Flag any non-decimal nibble on the operands being accepted
  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) any_bad = 1'b1;
    end
  end

  // Single digit adder with +6 decimal correction; subtract uses 9's complement of b
  always_comb begin
    a_d       = a_q[3:0];
    b_d       = b_q[3:0];
    bd        = sub_q ? 4'(4'd9 - b_d) : b_d;
    t         = 5'(a_d) + 5'(bd) + 5'(carry);
    digit     = t[3:0];
    carry_nxt = 1'b0;
    if (t > 5'd9) begin
      digit     = 4'(t + 5'd6);
      carry_nxt = 1'b1;
    end
  end

  // Place the current digit into its slot of the result
  always_comb begin
    sum_nxt = sum;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) sum_nxt[4*i +: 4] = digit;
    end
  end

  // Operand capture, digit sequencing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      invalid_r <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      invalid   <= 1'b0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      sub_q     <= sub;
      carry     <= sub ? ~cin : cin;
      invalid_r <= any_bad;
      cnt       <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> 4;
      b_q   <= b_q >> 4;
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      sum   <= sum_nxt;
      if (last) begin
        invalid <= invalid_r;
        cout    <= invalid_r ? 1'b0 : carry_nxt;
        if (invalid_r) sum <= '0;
      end
    end
  end

endmodule
